bench_response_capture: RTL and testbench
=========================================

// Module: bench_response_capture
// PURPOSE
//  Consumes the single-bit response (output_single) of a benchmark DUT over N clock cycles.
//  Per run it computes three results:
//   - a MISR signature of the sampled bits;
//   - a count of ones;
//   - a trace of the last DEPTH samples.
//  It then presents the signature on a valid/ready port.
//  It sits between the benchmark DUT and the result logger, so a run reduces to one compact
//  word for trojan detection.
// PARAMETERS
//  SIG_W  16       signature width, >= 4
//  POLY   16'h002D Galois MISR feedback (x^16+x^5+x^3+x^2+1), bit0 must be 1
//  CYC_W  16       width of the cycle counter and of ones_cnt
//  DEPTH  16       trace window length in samples
// PORTS
//  CK          in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low; 0 = in reset
//  start       in   1       one-cycle pulse; sampled only in IDLE
//  num_cycles  in   CYC_W   samples to capture; latched when start is accepted
//  dut_out     in   1       DUT response bit
//  busy        out  1       high from the cycle after start is accepted until DONE
//  sig         out  SIG_W   running/final MISR signature
//  ones_cnt    out  CYC_W   number of captured 1s, saturating
//  trace       out  DEPTH   last DEPTH samples; newest sample at bit 0
//  out_valid   out  1       final signature is available on out_data
//  out_ready   in   1       consumer accepts out_data
//  out_data    out  SIG_W   final signature, stable while out_valid && !out_ready
//  done        out  1       one-cycle pulse after the handshake completes
//  toggle_cnt  out  CYC_W   dut_out transition count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = IDLE;
//   - busy, out_valid and done = 0;
//   - sig, ones_cnt, trace, out_data and toggle_cnt = 0;
//   - the internal counter = 0.
//  FSM:
//   - IDLE:
//     - on start, latch num_cycles into rem and clear sig, ones_cnt, trace and toggle_cnt;
//     - go to CAPTURE if rem != 0, else to DRAIN.
//   - CAPTURE:
//     - on each edge sample dut_out with fb = sig[SIG_W-1] ^ dut_out;
//     - sig <= (sig<<1) ^ (fb ? POLY : 0);
//     - trace <= {trace[DEPTH-2:0], dut_out};
//     - ones_cnt += dut_out, saturating at all-ones;
//     - rem -= 1; when rem reaches 0, go to DRAIN.
//   - DRAIN:
//     - out_valid = 1 and out_data = sig;
//     - when out_valid && out_ready on an edge, go to DONE.
//   - DONE: done = 1 for exactly one cycle, busy drops, go to IDLE.
//  Latency:
//   - the first sample is taken on the edge after start is accepted;
//   - the last sample is taken N cycles later;
//   - out_valid is high on the cycle after the last sample.
//  Boundary conditions:
//   - start while not in IDLE is ignored, and num_cycles is not re-latched.
//   - num_cycles = 0: no samples; sig stays 0; DRAIN is entered directly.
//   - out_ready held low: out_valid stays high and out_data is held indefinitely.
//   - out_ready high in the same cycle out_valid first rises: DONE is entered the next cycle.
//   - dut_out is ignored outside CAPTURE.
//   - reset low mid-run aborts immediately to reset values; no done pulse.
//   - start in the same cycle as DONE is ignored; the next run needs start in IDLE.
// CONFIGURATION
//  RESP_TOGGLE_CNT_EN:
//   - defined: toggle_cnt counts cycles in CAPTURE where dut_out != the previous sample,
//     saturating at all-ones;
//   - for the first sample the previous sample is taken as 0;
//   - not defined: toggle_cnt is tied to 0 and there is no extra logic.
// STRUCTURE
//  Package bench_resp_pkg holds:
//   - the state typedef enum {IDLE, CAPTURE, DRAIN, DONE};
//   - default constants SIG_W_D, POLY_D, CYC_W_D and DEPTH_D;
//   - function misr_step(sig, bit, poly).
//  One sub-module, resp_misr: the SIG_W Galois register with clear and enable.
//  The FSM, counters and trace stay in the top module.
// TESTING
//  T1: N=4, dut_out=1,1,1,1 -> sig 002D,0077,00C3,01AB; out_data=16'h01AB; ones_cnt=4;
//      trace=16'h000F.
//  T2: N=8, dut_out=0 constant -> sig=0, ones_cnt=0, trace=0; out_valid rises 9 cycles after
//      start is accepted.
//  T3: N=0 -> out_valid on the cycle after start is accepted, out_data=0; then done with
//      out_ready=1.
//  T4: out_ready=0 for 5 cycles in DRAIN -> out_data stable at 01AB; done one cycle after
//      out_ready rises.
//  T5: reset low during CAPTURE at sample 2 -> all outputs 0, IDLE, no done; a new start with
//      N=4 all-ones gives 01AB.
//  T6 (RESP_TOGGLE_CNT_EN): N=6, dut_out 1,0,1,1,0,0 -> toggle_cnt=4, ones_cnt=3; without the
//      macro toggle_cnt=0.

Source files
------------

// File: rtl/bench_resp_pkg.sv
// rtl/bench_resp_pkg.sv - shared state type, default constants and MISR step for bench_response_capture
package bench_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int          SIG_W_D = 16;
    localparam logic [15:0] POLY_D  = 16'h002D;
    localparam int          CYC_W_D = 16;
    localparam int          DEPTH_D = 16;

    // Width-generic Galois step; callers zero-extend into and truncate out of 64 bits.
    function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                              input logic        bit_in,
                                              input logic [63:0] poly,
                                              input logic [6:0]  width);
        logic        fb;
        logic [63:0] mask;
        fb   = sig[6'(width - 7'd1)] ^ bit_in;
        mask = (width >= 7'd64) ? '1 : ((64'd1 << width) - 64'd1);
        return ((sig << 1) ^ (fb ? poly : 64'd0)) & mask;
    endfunction

endpackage

// File: rtl/bench_response_capture_if.sv
// rtl/bench_response_capture_if.sv - valid/ready result port carrying the final signature
interface bench_response_capture_if #(
    parameter int SIG_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/resp_misr.sv
// rtl/resp_misr.sv - SIG_W-bit Galois MISR with synchronous clear and enable
module resp_misr
    import bench_resp_pkg::*;
#(
    parameter int               SIG_W = SIG_W_D,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_D)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= SIG_W'(misr_step(64'(r_sig), i_bit, 64'(POLY), 7'(SIG_W)));
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/bench_response_capture.sv
// rtl/bench_response_capture.sv - reduces a benchmark DUT's response bit stream to MISR/ones/trace per run
// Optional feature macro: RESP_TOGGLE_CNT_EN (dut_out transition counter on toggle_cnt).
module bench_response_capture
    import bench_resp_pkg::*;
#(
    parameter int               SIG_W = SIG_W_D,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_D),
    parameter int               CYC_W = CYC_W_D,
    parameter int               DEPTH = DEPTH_D
) (
    input  logic                      CK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CYC_W-1:0]          num_cycles,
    input  logic                      dut_out,
    output logic                      busy,
    output logic [SIG_W-1:0]          sig,
    output logic [CYC_W-1:0]          ones_cnt,
    output logic [DEPTH-1:0]          trace,
    output logic                      done,
    output logic [CYC_W-1:0]          toggle_cnt,
    bench_response_capture_if.master  out_if
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CYC_W-1:0] r_rem;
    logic [CYC_W-1:0] r_ones;
    logic [DEPTH-1:0] r_trace;
    logic [SIG_W-1:0] w_sig;
    logic             w_start_acc;
    logic             w_capture;
    logic             w_out_valid;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_capture   = (r_state == CAPTURE);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        w_out_valid  = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (num_cycles != '0) ? CAPTURE : DRAIN;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (r_rem == CYC_W'(1)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy        = 1'b1;
                w_out_valid = 1'b1;
                if (out_if.out_ready) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // rem counts remaining samples; the run ends on the edge that takes the last one.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_rem   <= '0;
            r_ones  <= '0;
            r_trace <= '0;
        end else if (w_start_acc) begin
            r_rem   <= num_cycles;
            r_ones  <= '0;
            r_trace <= '0;
        end else if (w_capture) begin
            r_rem   <= r_rem - CYC_W'(1);
            r_trace <= {r_trace[DEPTH-2:0], dut_out};
            if (dut_out && (r_ones != '1)) begin
                r_ones <= r_ones + CYC_W'(1);
            end
        end
    end

    resp_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .i_clk   (CK),
        .i_rst_n (reset),
        .i_clr   (w_start_acc),
        .i_en    (w_capture),
        .i_bit   (dut_out),
        .o_sig   (w_sig)
    );

`ifdef RESP_TOGGLE_CNT_EN
    logic             r_prev;
    logic [CYC_W-1:0] r_tog;

    // The sample before the first one of a run counts as 0.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_tog  <= '0;
        end else if (w_start_acc) begin
            r_prev <= 1'b0;
            r_tog  <= '0;
        end else if (w_capture) begin
            r_prev <= dut_out;
            if ((dut_out != r_prev) && (r_tog != '1)) begin
                r_tog <= r_tog + CYC_W'(1);
            end
        end
    end

    assign toggle_cnt = r_tog;
`else
    assign toggle_cnt = '0;
`endif

    assign sig              = w_sig;
    assign ones_cnt         = r_ones;
    assign trace            = r_trace;
    assign out_if.out_valid = w_out_valid;
    assign out_if.out_data  = w_sig;

endmodule

// File: tb/tb_bench_response_capture.sv
// tb/tb_bench_response_capture.sv - scoreboard bench for bench_response_capture
module tb_bench_response_capture;

    localparam int          SIG_W = 16;
    localparam int          CYC_W = 16;
    localparam int          DEPTH = 16;
    localparam logic [15:0] POLY  = 16'h002D;

    logic             CK = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CYC_W-1:0] num_cycles = '0;
    logic             dut_out = 1'b0;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] sig;
    logic [CYC_W-1:0] ones_cnt;
    logic [DEPTH-1:0] trace;
    logic [CYC_W-1:0] toggle_cnt;

    bench_response_capture_if #(.SIG_W(SIG_W)) out_if ();

    bench_response_capture #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .CYC_W (CYC_W),
        .DEPTH (DEPTH)
    ) dut (
        .CK         (CK),
        .reset      (reset),
        .start      (start),
        .num_cycles (num_cycles),
        .dut_out    (dut_out),
        .busy       (busy),
        .sig        (sig),
        .ones_cnt   (ones_cnt),
        .trace      (trace),
        .done       (done),
        .toggle_cnt (toggle_cnt),
        .out_if     (out_if)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] ones;
        logic [15:0] trace;
        logic [15:0] tog;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: signature as repeated polynomial shift-and-reduce, counts by tallying the sample list.
    function automatic exp_t model(input bit b[$]);
        exp_t        e;
        logic [15:0] s;
        int          ones;
        int          tg;
        bit          prev;
        int          n;
        s    = 16'h0;
        ones = 0;
        tg   = 0;
        prev = 1'b0;
        n    = b.size();
        foreach (b[i]) begin
            s = {s[14:0], 1'b0} ^ (((s[15] ^ b[i]) == 1'b1) ? POLY : 16'h0000);
            ones += int'(b[i]);
            if (b[i] != prev) tg++;
            prev = b[i];
        end
        e.trace = 16'h0;
        for (int k = 0; k < 16 && k < n; k++) e.trace[k] = b[n-1-k];
        e.sig  = s;
        e.ones = (ones > 65535) ? 16'hFFFF : 16'(ones);
`ifdef RESP_TOGGLE_CNT_EN
        e.tog  = (tg > 65535) ? 16'hFFFF : 16'(tg);
`else
        e.tog  = 16'h0;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // One full run: start, feed samples, hold ready low rdy_dly cycles, complete handshake.
    task automatic run(input bit b[$], input int rdy_dly, input bit poke_start, input string tag);
        exp_t e;
        exp_t p;
        bit   pre[$];
        int   n;
        e = model(b);
        n = b.size();
        out_if.out_ready = 1'b0;
        start      = 1'b1;
        num_cycles = 16'(n);
        dut_out    = 1'($urandom);
        step();
        start = 1'b0;
        sb.push_back(e);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            dut_out = b[i];
            if (poke_start && i == 1) begin
                start      = 1'b1;
                num_cycles = 16'd3;
            end
            check({tag, "_valid_early"}, 32'(out_if.out_valid), 32'd0);
            step();
            start = 1'b0;
            pre.push_back(b[i]);
            p = model(pre);
            check({tag, "_run_sig"}, 32'(sig), 32'(p.sig));
        end
        dut_out = 1'($urandom);
        check({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
        check({tag, "_sig"}, 32'(sig), 32'(e.sig));
        for (int d = 0; d < rdy_dly; d++) begin
            dut_out = 1'($urandom);
            step();
            check({tag, "_hold_valid"}, 32'(out_if.out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_if.out_data), 32'(e.sig));
        end
        out_if.out_ready = 1'b1;
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_valid_done"}, 32'(out_if.out_valid), 32'd0);
        out_if.out_ready = 1'b0;
        start      = 1'b1;
        num_cycles = 16'd5;
        step();
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_start_in_done"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every accepted output is matched against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CK);
            if (reset && out_if.out_valid && out_if.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("mon_out_data", 32'(out_if.out_data), 32'(e.sig));
                    check("mon_ones_cnt", 32'(ones_cnt), 32'(e.ones));
                    check("mon_trace", 32'(trace), 32'(e.trace));
                    check("mon_toggle_cnt", 32'(toggle_cnt), 32'(e.tog));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit q[$];
        int n;
        out_if.out_ready = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_ones", 32'(ones_cnt), 32'd0);
        check("rst_trace", 32'(trace), 32'd0);
        check("rst_data", 32'(out_if.out_data), 32'd0);
        check("rst_toggle", 32'(toggle_cnt), 32'd0);
        reset = 1'b1;
        step();

        q = '{1, 1, 1, 1};
        run(q, 0, 1'b0, "t1");
        check("t1_sig_const", 32'(sig), 32'h01AB);
        check("t1_ones_const", 32'(ones_cnt), 32'd4);
        check("t1_trace_const", 32'(trace), 32'h000F);

        q = '{0, 0, 0, 0, 0, 0, 0, 0};
        run(q, 1, 1'b1, "t2");

        q.delete();
        run(q, 0, 1'b0, "t3");

        q = '{1, 1, 1, 1};
        run(q, 5, 1'b0, "t4");

        start      = 1'b1;
        num_cycles = 16'd4;
        step();
        start   = 1'b0;
        dut_out = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_sig", 32'(sig), 32'd0);
        check("t5_abort_ones", 32'(ones_cnt), 32'd0);
        check("t5_abort_trace", 32'(trace), 32'd0);
        check("t5_abort_valid", 32'(out_if.out_valid), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t5_idle_after", 32'(busy), 32'd0);
        q = '{1, 1, 1, 1};
        run(q, 0, 1'b0, "t5");
        check("t5_sig_const", 32'(sig), 32'h01AB);

        q = '{1, 0, 1, 1, 0, 0};
        run(q, 2, 1'b0, "t6");
        check("t6_ones", 32'(ones_cnt), 32'd3);
`ifdef RESP_TOGGLE_CNT_EN
        check("t6_toggle", 32'(toggle_cnt), 32'd4);
`else
        check("t6_toggle", 32'(toggle_cnt), 32'd0);
`endif

        for (int r = 0; r < 14; r++) begin
            q.delete();
            n = $urandom_range(0, 40);
            for (int k = 0; k < n; k++) q.push_back(1'($urandom));
            run(q, $urandom_range(0, 4), (n >= 2) && ($urandom_range(0, 1) == 1), "rnd");
        end

        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
